// File: rtl/hack_cpu_seq.sv
// hack_cpu_seq: multi-cycle Hack CPU sequencer with external ALU and split instruction/data ports
module hack_cpu_seq #(
    parameter logic [14:0] RESET_PC = 15'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_req,
    output logic [14:0] instr_addr,
    input  logic        instr_ack,
    input  logic [15:0] instr_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] pc
);
    typedef enum logic [2:0] {FETCH, DECODE, MREAD, EXEC, MWRITE, WB} state_t;
    state_t state;
    logic [15:0] a, d, m, r, ir;
    logic zr, ng, jump;
    assign instr_addr = pc;
    assign mem_addr   = a[14:0];
    assign mem_wdata  = r;
    assign alu_x      = d;
    assign alu_y      = ir[12] ? m : a;
    assign alu_ctl    = (state == EXEC) ? ir[11:6] : 6'b0;
    assign jump       = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
    // Sequencer: requests are registered and raised on entry to the state that owns them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            a         <= '0;
            d         <= '0;
            m         <= '0;
            r         <= '0;
            ir        <= '0;
            zr        <= 1'b0;
            ng        <= 1'b0;
            instr_req <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!instr_req) instr_req <= 1'b1;
                    else if (instr_ack) begin
                        ir        <= instr_data;
                        instr_req <= 1'b0;
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    if (!ir[15]) begin
                        a         <= {1'b0, ir[14:0]};
                        pc        <= pc + 15'd1;
                        instr_req <= 1'b1;
                        state     <= FETCH;
                    end else if (ir[12]) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        state   <= MREAD;
                    end else state <= EXEC;
                end
                MREAD: begin
                    if (mem_ack) begin
                        m       <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    r  <= alu_out;
                    zr <= alu_zr;
                    ng <= alu_ng;
                    if (ir[3]) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                        state   <= MWRITE;
                    end else state <= WB;
                end
                MWRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= WB;
                    end
                end
                WB: begin
                    if (ir[5]) a <= r;
                    if (ir[4]) d <= r;
                    pc        <= jump ? a[14:0] : pc + 15'd1;
                    instr_req <= 1'b1;
                    state     <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_hack_cpu_seq.sv
// tb_hack_cpu_seq: table-driven instruction stream plus reset/wait corner sequences
module tb_hack_cpu_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req, instr_ack = 1'b0;
    logic [14:0] instr_addr, mem_addr, pc;
    logic [15:0] instr_data = '0, mem_wdata, mem_rdata = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_ctl;
    logic        alu_zr, alu_ng;
    int checks = 0, failures = 0, both = 0;

    hack_cpu_seq dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_data(instr_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl), .alu_out(alu_out),
        .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc)
    );

    always #5 clk = ~clk;

    // Reference Hack ALU
    always_comb begin
        logic [15:0] x, y, o;
        x = alu_ctl[5] ? 16'h0 : alu_x;
        x = alu_ctl[4] ? ~x : x;
        y = alu_ctl[3] ? 16'h0 : alu_y;
        y = alu_ctl[2] ? ~y : y;
        o = alu_ctl[1] ? x + y : x & y;
        o = alu_ctl[0] ? ~o : o;
        alu_out = o;
        alu_zr  = (o == 16'h0);
        alu_ng  = o[15];
    end

    typedef struct {
        logic [15:0] ins;
        logic [15:0] rd;
        int          lat;
        logic [14:0] pc;
        logic [14:0] a;
        logic [15:0] d;
        int          cyc;
        int          wcnt;
        logic [14:0] wa;
        logic [15:0] wd;
        logic [5:0]  ctl;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Fetch one instruction with zero-wait ack, then serve data accesses until the next fetch
    task automatic step(input logic [15:0] ins, input logic [15:0] rd, input int lat,
                        output int cyc, output int wcnt, output logic [14:0] wa,
                        output logic [15:0] wd, output logic [5:0] ctl);
        int k = 0, cnt = 0;
        while (!instr_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("fetch_wait", {31'b0, instr_req}, 32'd1);
        instr_data = ins;
        instr_ack  = 1'b1;
        cyc = 0; wcnt = 0; wa = '0; wd = '0; ctl = '0;
        do begin
            @(negedge clk);
            cyc++;
            instr_ack = 1'b0;
            mem_ack   = 1'b0;
            if (instr_req && mem_req) both++;
            if (alu_ctl != 6'b0) ctl = alu_ctl;
            if (mem_req) begin
                cnt++;
                if (mem_we) wcnt++;
                if (cnt == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                    cnt       = 0;
                    if (mem_we) begin
                        wa = mem_addr;
                        wd = mem_wdata;
                    end
                end
            end
        end while (!instr_req && cyc < 50);
    endtask

    initial begin
        int cyc, wcnt, k;
        logic [14:0] wa;
        logic [15:0] wd;
        logic [5:0]  ctl;
        tbl[0]  = '{16'h0005, 16'h0,    1, 15'd1,     15'd5,     16'h0,    2, 0, 15'd0,  16'h0,    6'h00};
        tbl[1]  = '{16'hEC10, 16'h0,    1, 15'd2,     15'd5,     16'h5,    4, 0, 15'd0,  16'h0,    6'h30};
        tbl[2]  = '{16'h0007, 16'h0,    1, 15'd3,     15'd7,     16'h5,    2, 0, 15'd0,  16'h0,    6'h00};
        tbl[3]  = '{16'hEC10, 16'h0,    1, 15'd4,     15'd7,     16'h7,    4, 0, 15'd0,  16'h0,    6'h30};
        tbl[4]  = '{16'h0064, 16'h0,    1, 15'd5,     15'd100,   16'h7,    2, 0, 15'd0,  16'h0,    6'h00};
        tbl[5]  = '{16'hE7C8, 16'h0,    3, 15'd6,     15'd100,   16'h7,    7, 3, 15'd100, 16'h8,   6'h1F};
        tbl[6]  = '{16'h0014, 16'h0,    1, 15'd7,     15'd20,    16'h7,    2, 0, 15'd0,  16'h0,    6'h00};
        tbl[7]  = '{16'hEA90, 16'h0,    1, 15'd8,     15'd20,    16'h0,    4, 0, 15'd0,  16'h0,    6'h2A};
        tbl[8]  = '{16'hE302, 16'h0,    1, 15'd20,    15'd20,    16'h0,    4, 0, 15'd0,  16'h0,    6'h0C};
        tbl[9]  = '{16'h0003, 16'h0,    1, 15'd21,    15'd3,     16'h0,    2, 0, 15'd0,  16'h0,    6'h00};
        tbl[10] = '{16'hEC10, 16'h0,    1, 15'd22,    15'd3,     16'h3,    4, 0, 15'd0,  16'h0,    6'h30};
        tbl[11] = '{16'h0014, 16'h0,    1, 15'd23,    15'd20,    16'h3,    2, 0, 15'd0,  16'h0,    6'h00};
        tbl[12] = '{16'hE302, 16'h0,    1, 15'd24,    15'd20,    16'h3,    4, 0, 15'd0,  16'h0,    6'h0C};
        tbl[13] = '{16'hFC10, 16'h1234, 2, 15'd25,    15'd20,    16'h1234, 6, 0, 15'd0,  16'h0,    6'h30};
        tbl[14] = '{16'hF088, 16'h0010, 1, 15'd26,    15'd20,    16'h1234, 6, 1, 15'd20, 16'h1244, 6'h02};
        tbl[15] = '{16'h001E, 16'h0,    1, 15'd27,    15'd30,    16'h1234, 2, 0, 15'd0,  16'h0,    6'h00};
        tbl[16] = '{16'hEA87, 16'h0,    1, 15'd30,    15'd30,    16'h1234, 4, 0, 15'd0,  16'h0,    6'h2A};
        tbl[17] = '{16'hE7E1, 16'h0,    1, 15'd30,    15'h1235,  16'h1234, 4, 0, 15'd0,  16'h0,    6'h1F};
        tbl[18] = '{16'hEE90, 16'h0,    1, 15'd31,    15'h1235,  16'hFFFF, 4, 0, 15'd0,  16'h0,    6'h3A};
        tbl[19] = '{16'hE304, 16'h0,    1, 15'h1235,  15'h1235,  16'hFFFF, 4, 0, 15'd0,  16'h0,    6'h0C};
        tbl[20] = '{16'h7FFF, 16'h0,    1, 15'h1236,  15'h7FFF,  16'hFFFF, 2, 0, 15'd0,  16'h0,    6'h00};
        tbl[21] = '{16'hEA87, 16'h0,    1, 15'h7FFF,  15'h7FFF,  16'hFFFF, 4, 0, 15'd0,  16'h0,    6'h2A};
        tbl[22] = '{16'h0001, 16'h0,    1, 15'h0000,  15'h0001,  16'hFFFF, 2, 0, 15'd0,  16'h0,    6'h00};
        tbl[23] = '{16'hE301, 16'h0,    1, 15'h0001,  15'h0001,  16'hFFFF, 4, 0, 15'd0,  16'h0,    6'h0C};

        repeat (2) @(negedge clk);
        chk("rst_instr_req", {31'b0, instr_req}, 32'd0);
        chk("rst_mem_req", {30'b0, mem_req, mem_we}, 32'd0);
        chk("rst_pc", {17'b0, instr_addr}, 32'd0);
        chk("rst_ctl", {26'b0, alu_ctl}, 32'd0);
        chk("rst_ad", {1'b0, mem_addr, alu_x}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req", {31'b0, instr_req}, 32'd1);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].ins, tbl[i].rd, tbl[i].lat, cyc, wcnt, wa, wd, ctl);
            chk($sformatf("v%0d_pc", i), {17'b0, pc}, {17'b0, tbl[i].pc});
            chk($sformatf("v%0d_a", i), {17'b0, mem_addr}, {17'b0, tbl[i].a});
            chk($sformatf("v%0d_d", i), {16'b0, alu_x}, {16'b0, tbl[i].d});
            chk($sformatf("v%0d_cyc", i), cyc, tbl[i].cyc);
            chk($sformatf("v%0d_wcnt", i), wcnt, tbl[i].wcnt);
            chk($sformatf("v%0d_ctl", i), {26'b0, ctl}, {26'b0, tbl[i].ctl});
            if (tbl[i].wcnt > 0) begin
                chk($sformatf("v%0d_waddr", i), {17'b0, wa}, {17'b0, tbl[i].wa});
                chk($sformatf("v%0d_wdata", i), {16'b0, wd}, {16'b0, tbl[i].wd});
            end
        end

        // Held fetch with stray mem_ack: request must stay up, no data request
        k = 0;
        mem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (instr_req && !mem_req) k++;
        end
        mem_ack = 1'b0;
        chk("fetch_hold", k, 3);
        step(16'h0042, 16'h0, 1, cyc, wcnt, wa, wd, ctl);
        chk("hold_pc", {17'b0, pc}, 32'd2);
        chk("hold_a", {17'b0, mem_addr}, 32'h42);

        // Reset while MREAD waits for mem_ack
        instr_data = 16'hFC10;
        instr_ack  = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        k = 0;
        while (!mem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mread_req", {30'b0, mem_req, mem_we}, 32'd2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_req", {30'b0, mem_req, mem_we}, 32'd0);
        chk("arst_instr_req", {31'b0, instr_req}, 32'd0);
        chk("arst_pc", {17'b0, pc}, 32'd0);
        chk("arst_ad", {1'b0, mem_addr, alu_x}, 32'd0);
        repeat (2) @(negedge clk);
        chk("arst_hold_req", {30'b0, instr_req, mem_req}, 32'd0);
        reset   = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rel_req", {30'b0, instr_req, mem_req}, 32'd2);
        chk("rel_addr", {17'b0, instr_addr}, 32'd0);
        step(16'h0009, 16'h0, 1, cyc, wcnt, wa, wd, ctl);
        chk("rel_pc", {17'b0, pc}, 32'd1);
        chk("rel_a", {17'b0, mem_addr}, 32'd9);
        chk("rel_d", {16'b0, alu_x}, 32'd0);
        chk("rel_cyc", cyc, 2);
        chk("req_overlap", both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hack_cpu_seq.md
HACK_CPU_SEQ -- requirements
Module: hack_cpu_seq

Interface
REQ-001 Parameter: RESET_PC, default 15'd0, PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instr_req  output  1  instruction fetch request.
REQ-005 instr_addr  output  15  fetch address, equal to PC.
REQ-006 instr_ack  input  1  fetch complete; instr_data valid this cycle.
REQ-007 instr_data  input  16  fetched Hack instruction.
REQ-008 mem_req  output  1  data memory request.
REQ-009 mem_we  output  1  1=write, 0=read; valid only while mem_req=1.
REQ-010 mem_addr  output  15  data address, equal to A[14:0].
REQ-011 mem_wdata  output  16  write data, equal to the captured ALU result R.
REQ-012 mem_ack  input  1  data access complete; mem_rdata valid this cycle on a read.
REQ-013 mem_rdata  input  16  read data.
REQ-014 alu_x  output  16  ALU x operand, equal to D.
REQ-015 alu_y  output  16  ALU y operand, M latch if IR[12]=1, else A.
REQ-016 alu_ctl  output  6  {zx,nx,zy,ny,f,no}; IR[11:6] in EXEC, 6'b0 otherwise.
REQ-017 alu_out  input  16  ALU result, combinational from alu_x/alu_y/alu_ctl.
REQ-018 alu_zr, alu_ng  input  1 each  ALU zero and negative flags.
REQ-019 pc  output  15  current program counter.

Function
REQ-020 The block SHALL implement a one-hot-or-encoded FSM with states FETCH, DECODE, MREAD, EXEC, MWRITE, WB.
REQ-021 FETCH: instr_req=1 held until instr_ack; on ack, IR<=instr_data, next DECODE; ack in the same cycle as req completes the fetch (1 cycle minimum).
REQ-022 DECODE, IR[15]=0 (A-instruction): A<={1'b0,IR[14:0]}, PC<=PC+1, next FETCH.
REQ-023 DECODE, IR[15]=1 (C-instruction): next MREAD if IR[12]=1, else EXEC.
REQ-024 MREAD: mem_req=1, mem_we=0, held until mem_ack; on ack, M<=mem_rdata, next EXEC.
REQ-025 EXEC: alu_ctl=IR[11:6]; R<=alu_out, ZR<=alu_zr, NG<=alu_ng; next MWRITE if IR[3]=1, else WB.
REQ-026 MWRITE: mem_req=1, mem_we=1, mem_addr=A[14:0] (pre-update A), mem_wdata=R, held until mem_ack, then WB.
REQ-027 WB: if IR[5] A<=R; if IR[4] D<=R; PC<=A[14:0] (pre-update A) if jump taken else PC+1; next FETCH.
REQ-028 Jump taken = (IR[2]&NG) | (IR[1]&ZR) | (IR[0]&~NG&~ZR); IR[2:0]=3'b111 always jumps; 3'b000 never.
REQ-029 PC arithmetic SHALL be 15-bit modulo: PC+1 from 15'h7FFF wraps to 15'h0000.
REQ-030 instr_ack outside FETCH and mem_ack outside MREAD/MWRITE SHALL be ignored.
REQ-031 instr_req and mem_req SHALL never be asserted in the same cycle.
REQ-032 Requests SHALL deassert in the cycle following the accepting ack (no back-to-back issue within one state).
REQ-033 Minimum cycle counts (zero-wait acks): A-instr 2, C-instr without M read/write 4, with both 6.

Reset
REQ-034 On reset assertion, state SHALL go to FETCH immediately (asynchronously), including mid-transaction; pending requests are abandoned.
REQ-035 Reset values: PC=RESET_PC, A=0, D=0, M=0, R=0, IR=0, ZR=0, NG=0; hence instr_req=0 while reset is high, mem_req=0, mem_we=0, alu_ctl=0, instr_addr=RESET_PC.
REQ-036 After reset deassertion, instr_req SHALL assert on the first rising edge's following cycle with instr_addr=RESET_PC.

Verification
REQ-037 Fetch 16'h0005 at PC 0, zero-wait -> A=5, PC=1 after 2 cycles, no mem_req.
REQ-038 A=5, fetch D=A (16'hEC10) -> alu_ctl=6'b110000 in EXEC, D=5, PC+1, no mem_req.
REQ-039 A=100, fetch M=D+1 (16'hE7C8), D=7, mem_ack delayed 3 cycles -> mem_req/mem_we held 3 cycles, addr 100, wdata 8, then PC+1.
REQ-040 A=20, fetch D;JEQ (16'hE302) with D=0 -> PC=20; with D=3 -> PC+1.
REQ-041 PC=15'h7FFF, A-instruction -> PC wraps to 0.
REQ-042 Reset asserted while MREAD waits for mem_ack -> mem_req drops asynchronously, all registers at reset values, FETCH from RESET_PC after release; stray mem_ack then ignored.
